alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU op encodings and sequencer FSM states.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;

   localparam logic [3:0] LAST_LEGAL_OP = OP_SHR;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } seqState_t;

   // Shift ops run one single-bit ALU step per requested shift position.
   function automatic logic isShiftOp(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Feeds an external single-cycle ALU, iterating shift ops one bit per cycle,
// and returns the final result and flags through a valid/ready response port.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             cmdValid,
   output logic             cmdReady,
   input  logic [WIDTH-1:0] cmdA,
   input  logic [WIDTH-1:0] cmdB,
   input  logic [3:0]       cmdOp,
   input  logic [SHW-1:0]   cmdShAmt,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   output logic [3:0]       aluOp,
   input  logic [WIDTH-1:0] aluResult,
   input  logic             aluZero,
   input  logic             aluCarry,
   output logic             rspValid,
   input  logic             rspReady,
   output logic [WIDTH-1:0] rspResult,
   output logic             rspZero,
   output logic             rspCarry,
   output logic             rspIllegal,
   output logic             busy
);

   seqState_t        state;
   seqState_t        nextState;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] bReg;
   logic [3:0]       opReg;
   logic [SHW-1:0]   iterCnt;
   logic [SHW-1:0]   cmdIter;
   logic             zeroReg;
   logic             carryReg;
   logic             illegalReg;
   logic             cmdIllegal;
   logic             accept;

   // Iteration count of the offered command: illegal ops never touch the ALU,
   // shifts saturate at WIDTH since further steps cannot change the result.
   always_comb begin
      cmdIter    = '0;
      cmdIllegal = (cmdOp > LAST_LEGAL_OP);
      if (cmdIllegal) begin
         cmdIter = '0;
      end else if (isShiftOp(cmdOp)) begin
         cmdIter = (cmdShAmt > SHW'(WIDTH)) ? SHW'(WIDTH) : cmdShAmt;
      end else begin
         cmdIter = SHW'(1);
      end
   end

   assign accept = cmdValid && (state == IDLE);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and output decode; ALU and response buses are zero outside
   // their own state so nothing stale leaks to the ALU or downstream.
   always_comb begin
      nextState  = state;
      cmdReady   = 1'b0;
      rspValid   = 1'b0;
      busy       = 1'b1;
      aluA       = '0;
      aluB       = '0;
      aluOp      = '0;
      rspResult  = '0;
      rspZero    = 1'b0;
      rspCarry   = 1'b0;
      rspIllegal = 1'b0;
      case (state)
         IDLE: begin
            cmdReady = 1'b1;
            busy     = 1'b0;
            if (accept) begin
               nextState = (cmdIter != '0) ? EXEC : RESP;
            end
         end
         EXEC: begin
            aluA  = acc;
            aluB  = bReg;
            aluOp = opReg;
            if (iterCnt == SHW'(1)) begin
               nextState = RESP;
            end
         end
         RESP: begin
            rspValid   = 1'b1;
            rspResult  = acc;
            rspZero    = zeroReg;
            rspCarry   = carryReg;
            rspIllegal = illegalReg;
            if (rspReady) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath: the acceptance edge preloads the final response for zero-iteration
   // commands, otherwise each EXEC edge folds the ALU output back into acc.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         acc        <= '0;
         bReg       <= '0;
         opReg      <= '0;
         iterCnt    <= '0;
         zeroReg    <= 1'b0;
         carryReg   <= 1'b0;
         illegalReg <= 1'b0;
      end else if (accept) begin
         bReg       <= cmdB;
         opReg      <= cmdOp;
         iterCnt    <= cmdIter;
         carryReg   <= 1'b0;
         illegalReg <= cmdIllegal;
         if (cmdIllegal) begin
            acc     <= '0;
            zeroReg <= 1'b1;
         end else begin
            acc     <= cmdA;
            zeroReg <= (cmdA == '0);
         end
      end else if (state == EXEC) begin
         acc      <= aluResult;
         zeroReg  <= aluZero;
         carryReg <= aluCarry;
         iterCnt  <= iterCnt - SHW'(1);
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer with a behavioural ALU stand-in
// and a closed-form reference model of each command's final response.
module tb_alu_sequencer;

   localparam int WIDTH = 32;
   localparam int SHW   = $clog2(WIDTH) + 1;

   logic             clk;
   logic             rstN;
   logic             cmdValid;
   logic             cmdReady;
   logic [WIDTH-1:0] cmdA;
   logic [WIDTH-1:0] cmdB;
   logic [3:0]       cmdOp;
   logic [SHW-1:0]   cmdShAmt;
   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [3:0]       aluOp;
   logic [WIDTH-1:0] aluResult;
   logic             aluZero;
   logic             aluCarry;
   logic             rspValid;
   logic             rspReady;
   logic [WIDTH-1:0] rspResult;
   logic             rspZero;
   logic             rspCarry;
   logic             rspIllegal;
   logic             busy;

   int cmpCount  = 0;
   int failCount = 0;

   logic [WIDTH-1:0] lastRes;
   logic             lastZero;
   logic             lastCarry;
   logic             lastIll;
   int               lastLatency;

   alu_sequencer #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk(clk), .rstN(rstN),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdA(cmdA), .cmdB(cmdB), .cmdOp(cmdOp), .cmdShAmt(cmdShAmt),
      .aluA(aluA), .aluB(aluB), .aluOp(aluOp),
      .aluResult(aluResult), .aluZero(aluZero), .aluCarry(aluCarry),
      .rspValid(rspValid), .rspReady(rspReady),
      .rspResult(rspResult), .rspZero(rspZero), .rspCarry(rspCarry),
      .rspIllegal(rspIllegal), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the external ALU: shifts move one bit per step.
   always_comb begin
      logic [WIDTH:0] wide;
      wide      = '0;
      aluResult = '0;
      aluCarry  = 1'b0;
      case (aluOp)
         4'b0000: begin wide = {1'b0, aluA} + {1'b0, aluB}; aluResult = wide[WIDTH-1:0]; aluCarry = wide[WIDTH]; end
         4'b0001: begin wide = {1'b0, aluA} - {1'b0, aluB}; aluResult = wide[WIDTH-1:0]; aluCarry = wide[WIDTH]; end
         4'b0010: aluResult = aluA & aluB;
         4'b0011: aluResult = aluA | aluB;
         4'b0100: aluResult = aluA ^ aluB;
         4'b0101: aluResult = ($signed(aluA) < $signed(aluB)) ? WIDTH'(1) : '0;
         4'b0110: begin aluResult = aluA << 1; aluCarry = aluA[WIDTH-1]; end
         4'b0111: aluResult = aluA >> 1;
         default: aluResult = '0;
      endcase
      aluZero = (aluResult == '0);
   end

   // Closed-form expected response of a whole command.
   task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [3:0] op, input int sh,
                           output logic [WIDTH-1:0] res, output logic z,
                           output logic c, output logic ill, output int k);
      logic [2*WIDTH-1:0] wideShift;
      logic [WIDTH:0]     wide;
      res = '0; c = 1'b0; ill = 1'b0; k = 1;
      case (op)
         4'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[WIDTH-1:0]; c = wide[WIDTH]; end
         4'd1: begin wide = {1'b0, a} - {1'b0, b}; res = wide[WIDTH-1:0]; c = wide[WIDTH]; end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         4'd6, 4'd7: begin
            k = (sh > WIDTH) ? WIDTH : sh;
            if (op == 4'd6) begin
               wideShift = {{WIDTH{1'b0}}, a} << k;
               res = wideShift[WIDTH-1:0];
               c   = (k > 0) ? wideShift[WIDTH] : 1'b0;
            end else begin
               res = a >> k;
            end
         end
         default: begin ill = 1'b1; k = 0; end
      endcase
      z = (res == '0);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      cmpCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One full command: offer, watch EXEC, check latency and response, hold, release.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [3:0] op, input int sh, input int holdCycles);
      logic [WIDTH-1:0] expRes;
      logic expZ, expC, expIll;
      int   expK;
      int   cyc;
      refModel(a, b, op, sh, expRes, expZ, expC, expIll, expK);
      @(negedge clk);
      checkOutput("cmdReadyIdle", 64'(cmdReady), 64'(1));
      cmdValid = 1'b1; cmdA = a; cmdB = b; cmdOp = op; cmdShAmt = SHW'(sh);
      @(posedge clk); #1;
      cmdValid = 1'b0;
      cyc = 0;
      while (!rspValid && cyc < 100) begin
         checkOutput("aluOpExec", 64'(aluOp), 64'(op));
         checkOutput("aluBExec", 64'(aluB), 64'(b));
         @(posedge clk); #1;
         cyc++;
      end
      lastLatency = cyc;
      checkOutput("latency", 64'(cyc), 64'(expK));
      lastRes = rspResult; lastZero = rspZero; lastCarry = rspCarry; lastIll = rspIllegal;
      checkOutput("rspResult", 64'(rspResult), 64'(expRes));
      checkOutput("rspZero", 64'(rspZero), 64'(expZ));
      checkOutput("rspCarry", 64'(rspCarry), 64'(expC));
      checkOutput("rspIllegal", 64'(rspIllegal), 64'(expIll));
      checkOutput("aluOpResp", 64'(aluOp), 64'(0));
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk); #1;
         checkOutput("holdValid", 64'(rspValid), 64'(1));
         checkOutput("holdResult", 64'(rspResult), 64'(expRes));
         checkOutput("holdFlags", 64'({rspZero, rspCarry, rspIllegal}), 64'({expZ, expC, expIll}));
         checkOutput("holdCmdReady", 64'(cmdReady), 64'(0));
      end
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      checkOutput("backIdle", 64'({cmdReady, rspValid, busy}), 64'(3'b100));
   endtask

   initial begin
      cmdValid = 1'b0; cmdA = '0; cmdB = '0; cmdOp = '0; cmdShAmt = '0; rspReady = 1'b0;
      rstN = 1'b0;
      #12;
      checkOutput("resetCmdReady", 64'(cmdReady), 64'(1));
      checkOutput("resetOutputs", 64'({rspValid, busy, aluOp}), 64'(0));
      checkOutput("resetRsp", 64'(rspResult), 64'(0));
      @(negedge clk); rstN = 1'b1;

      applyStimulus(32'd5, 32'd7, 4'b0000, 0, 0);
      checkOutput("addResult", 64'(lastRes), 64'(12));
      checkOutput("addLatency", 64'(lastLatency), 64'(1));
      applyStimulus(32'd3, 32'd3, 4'b0001, 0, 1);
      checkOutput("subZero", 64'({lastZero, lastIll}), 64'(2'b10));
      applyStimulus(32'h1000_0001, 32'd0, 4'b0110, 4, 0);
      checkOutput("shlResult", 64'({lastCarry, lastRes}), 64'({1'b1, 32'h0000_0010}));
      applyStimulus(32'hFFFF_FFFF, 32'd0, 4'b0111, 40, 0);
      checkOutput("shrSat", 64'({lastZero, lastCarry, lastLatency}), 64'({1'b1, 1'b0, 32'd32}));
      applyStimulus(32'h1234_5678, 32'd9, 4'b1010, 0, 5);
      checkOutput("illegal", 64'({lastIll, lastRes}), 64'({1'b1, 32'd0}));
      applyStimulus(32'h0, 32'd0, 4'b0110, 0, 0);
      applyStimulus(32'h8000_0000, 32'd0, 4'b0110, 0, 2);

      for (int n = 0; n < 30; n++) begin
         logic [3:0] op;
         int sh;
         op = 4'($urandom_range(0, 15));
         sh = (n % 5 == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 12));
         applyStimulus($urandom, (n % 4 == 0) ? 32'hFFFF_FFFF : $urandom, op, sh, $urandom_range(0, 3));
      end

      // Reset in the middle of a 20-step shift must discard it.
      @(negedge clk);
      cmdValid = 1'b1; cmdA = 32'hA5A5_A5A5; cmdOp = 4'b0110; cmdShAmt = SHW'(20);
      @(posedge clk); #1;
      cmdValid = 1'b0;
      rspReady = 1'b1;
      repeat (9) @(posedge clk);
      #3;
      checkOutput("midExecAluOp", 64'(aluOp), 64'(6));
      rstN = 1'b0;
      #1;
      checkOutput("rstAluOp", 64'({aluOp, aluA}), 64'(0));
      checkOutput("rstRsp", 64'({rspValid, busy}), 64'(0));
      @(negedge clk); rstN = 1'b1;
      #1;
      checkOutput("rstCmdReady", 64'(cmdReady), 64'(1));
      begin
         int seen;
         seen = 0;
         repeat (30) begin
            @(posedge clk); #1;
            if (rspValid) seen++;
         end
         checkOutput("noStaleRsp", 64'(seen), 64'(0));
      end
      rspReady = 1'b0;
      applyStimulus(32'd100, 32'd1, 4'b0001, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
